// File: rtl/pmt_access_arbiter_if.sv
// rtl/pmt_access_arbiter_if.sv - Requester, PMT pool and response signals of the PMT access arbiter
interface pmt_access_arbiter_if #(
   parameter int NUM_REQ = 5,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 64
);
   logic                      search_busy;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        req_wr;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ*DATA_W-1:0] req_mask;
   logic                      pmt_wr_en;
   logic [ADDR_W-1:0]         pmt_wr_addr;
   logic [DATA_W-1:0]         pmt_wr_data;
   logic [DATA_W-1:0]         pmt_wr_mask;
   logic                      pmt_rd_en;
   logic [ADDR_W-1:0]         pmt_rd_addr;
   logic                      pmt_rd_valid;
   logic [DATA_W-1:0]         pmt_rd_data;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      rsp_err;

   modport master (
      input  search_busy, req_valid, req_wr, req_addr, req_data, req_mask,
      input  pmt_rd_valid, pmt_rd_data,
      output req_ready, pmt_wr_en, pmt_wr_addr, pmt_wr_data, pmt_wr_mask,
      output pmt_rd_en, pmt_rd_addr, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      output search_busy, req_valid, req_wr, req_addr, req_data, req_mask,
      output pmt_rd_valid, pmt_rd_data,
      input  req_ready, pmt_wr_en, pmt_wr_addr, pmt_wr_data, pmt_wr_mask,
      input  pmt_rd_en, pmt_rd_addr, rsp_valid, rsp_data, rsp_err
   );
endinterface

// File: rtl/pmt_access_arbiter.sv
// rtl/pmt_access_arbiter.sv - Round-robin arbiter sharing one PMT pool port among NUM_REQ LMT requesters
// Optional read-response timeout is built only when PMT_ARB_TIMEOUT_EN is defined.
module pmt_access_arbiter #(
   parameter int NUM_REQ     = 5,
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   pmt_access_arbiter_if.master bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [0:0] {IDLE, WAIT_RD} state_t;

   state_t              state, state_next;
   logic [PTR_W-1:0]    rr_ptr, tag, grant_idx;
   logic                grant_any, xfer, rd_done, timeout_hit;
   logic                sel_wr;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data, sel_mask;

   logic                wr_en_q, rd_en_q;
   logic [ADDR_W-1:0]   wr_addr_q, rd_addr_q;
   logic [DATA_W-1:0]   wr_data_q, wr_mask_q, rsp_data_q;
   logic [NUM_REQ-1:0]  rsp_valid_q;

   // Scan from the requester after the last winner, wrapping once around.
   always_comb begin
      int idx;
      idx       = 0;
      grant_any = 1'b0;
      grant_idx = '0;
      sel_wr    = 1'b0;
      sel_addr  = '0;
      sel_data  = '0;
      sel_mask  = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_any && bus.req_valid[idx]) begin
            grant_any = 1'b1;
            grant_idx = idx[PTR_W-1:0];
            sel_wr    = bus.req_wr[idx];
            sel_addr  = bus.req_addr[idx*ADDR_W +: ADDR_W];
            sel_data  = bus.req_data[idx*DATA_W +: DATA_W];
            sel_mask  = bus.req_mask[idx*DATA_W +: DATA_W];
         end
      end
   end

   assign xfer          = grant_any && (state == IDLE) && !bus.search_busy && !rst;
   assign bus.req_ready = xfer ? (NUM_REQ'(1) << grant_idx) : '0;
   assign rd_done       = (state == WAIT_RD) && (bus.pmt_rd_valid || timeout_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (xfer && !sel_wr) state_next = WAIT_RD;
         WAIT_RD: if (rd_done)         state_next = IDLE;
         default:                      state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr      <= PTR_W'(NUM_REQ - 1);
         tag         <= '0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_mask_q   <= '0;
         rd_en_q     <= 1'b0;
         rd_addr_q   <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
      end else begin
         wr_en_q     <= 1'b0;
         rd_en_q     <= 1'b0;
         rsp_valid_q <= '0;
         if (xfer) begin
            rr_ptr <= grant_idx;
            if (sel_wr) begin
               wr_en_q   <= 1'b1;
               wr_addr_q <= sel_addr;
               wr_data_q <= sel_data;
               wr_mask_q <= sel_mask;
            end else begin
               rd_en_q   <= 1'b1;
               rd_addr_q <= sel_addr;
               tag       <= grant_idx;
            end
         end
         // A timeout response carries zero data; real data always wins a tie.
         if (rd_done) begin
            rsp_valid_q <= NUM_REQ'(1) << tag;
            rsp_data_q  <= bus.pmt_rd_valid ? bus.pmt_rd_data : '0;
         end
      end
   end

`ifdef PMT_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

   logic [CNT_W-1:0] to_cnt;
   logic             rsp_err_q;

   assign timeout_hit = (state == WAIT_RD) && (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt    <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         to_cnt <= (state == WAIT_RD) ? to_cnt + 1'b1 : '0;
         if (rd_done) rsp_err_q <= !bus.pmt_rd_valid;
      end
   end

   assign bus.rsp_err = rsp_err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC == 0);
   assign timeout_hit    = 1'b0;
   assign bus.rsp_err    = 1'b0;
`endif

   assign bus.pmt_wr_en   = wr_en_q;
   assign bus.pmt_wr_addr = wr_addr_q;
   assign bus.pmt_wr_data = wr_data_q;
   assign bus.pmt_wr_mask = wr_mask_q;
   assign bus.pmt_rd_en   = rd_en_q;
   assign bus.pmt_rd_addr = rd_addr_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
endmodule

// File: tb/tb_pmt_access_arbiter.sv
// tb/tb_pmt_access_arbiter.sv - Directed scoreboard bench for pmt_access_arbiter
// Timeout cases run only when PMT_ARB_TIMEOUT_EN is defined.
module tb_pmt_access_arbiter;
   localparam int NUM_REQ     = 5;
   localparam int ADDR_W      = 8;
   localparam int DATA_W      = 64;
   localparam int TIMEOUT_CYC = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pmt_access_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   pmt_access_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] mask;
   } wr_t;

   typedef struct packed {
      logic [NUM_REQ-1:0] valid;
      logic [DATA_W-1:0]  data;
      logic               err;
   } rsp_t;

   wr_t               wr_q[$];
   logic [ADDR_W-1:0] rd_q[$];
   rsp_t              rsp_q[$];
   int                vectors     = 0;
   int                miscompares = 0;
   int                order[4]    = '{0, 2, 4, 0};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NUM_REQ-1:0] oh(input int i);
      oh = NUM_REQ'(1) << i;
   endfunction

   function automatic logic [ADDR_W-1:0] a_of(input int i);
      a_of = 8'h10 + ADDR_W'(i);
   endfunction

   function automatic logic [DATA_W-1:0] d_of(input int i);
      d_of = 64'hA5A5_0000_0000_0000 | (64'h111 * DATA_W'(i + 1));
   endfunction

   function automatic logic [DATA_W-1:0] m_of(input int i);
      m_of = ~64'h0 >> (8 * i);
   endfunction

   task automatic set_req(input int i, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
      bus.req_wr[i]                   = wr;
      bus.req_addr[i*ADDR_W +: ADDR_W] = a;
      bus.req_data[i*DATA_W +: DATA_W] = d;
      bus.req_mask[i*DATA_W +: DATA_W] = m;
   endtask

   task automatic push_wr(input int i);
      wr_t w;
      w.addr = a_of(i);
      w.data = d_of(i);
      w.mask = m_of(i);
      wr_q.push_back(w);
   endtask

   task automatic push_rsp(input logic [NUM_REQ-1:0] v, input logic [DATA_W-1:0] d, input logic e);
      rsp_t r;
      r.valid = v;
      r.data  = d;
      r.err   = e;
      rsp_q.push_back(r);
   endtask

   // Pops the scoreboard whenever the DUT presents a write, read or response.
   task automatic monitor();
      wr_t               w;
      rsp_t              r;
      logic [ADDR_W-1:0] a;
      chk("wr_rd_exclusive", bus.pmt_wr_en & bus.pmt_rd_en, 64'd0);
      if (bus.pmt_wr_en) begin
         if (wr_q.size() == 0) chk("wr_unexpected", bus.pmt_wr_en, 64'd0);
         else begin
            w = wr_q.pop_front();
            chk("wr_addr", bus.pmt_wr_addr, w.addr);
            chk("wr_data", bus.pmt_wr_data, w.data);
            chk("wr_mask", bus.pmt_wr_mask, w.mask);
         end
      end
      if (bus.pmt_rd_en) begin
         if (rd_q.size() == 0) chk("rd_unexpected", bus.pmt_rd_en, 64'd0);
         else begin
            a = rd_q.pop_front();
            chk("rd_addr", bus.pmt_rd_addr, a);
         end
      end
      if (bus.rsp_valid != '0) begin
         if (rsp_q.size() == 0) chk("rsp_unexpected", bus.rsp_valid, 64'd0);
         else begin
            r = rsp_q.pop_front();
            chk("rsp_valid", bus.rsp_valid, r.valid);
            chk("rsp_data", bus.rsp_data, r.data);
            chk("rsp_err", bus.rsp_err, r.err);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      monitor();
   endtask

   initial begin
      bus.search_busy  = 1'b0;
      bus.req_valid    = '1;
      bus.req_wr       = '0;
      bus.req_addr     = '0;
      bus.req_data     = '0;
      bus.req_mask     = '0;
      bus.pmt_rd_valid = 1'b0;
      bus.pmt_rd_data  = '0;

      // Reset state with every requester asking
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", bus.req_ready, 64'd0);
      chk("rst_wr_en", bus.pmt_wr_en, 64'd0);
      chk("rst_rd_en", bus.pmt_rd_en, 64'd0);
      chk("rst_wr_addr", bus.pmt_wr_addr, 64'd0);
      chk("rst_wr_data", bus.pmt_wr_data, 64'd0);
      chk("rst_rd_addr", bus.pmt_rd_addr, 64'd0);
      chk("rst_rsp_valid", bus.rsp_valid, 64'd0);
      chk("rst_rsp_data", bus.rsp_data, 64'd0);
      chk("rst_rsp_err", bus.rsp_err, 64'd0);

      // Requesters 0,2,4 write from reset: grants 0,2,4,0 back to back
      bus.req_valid = 5'b10101;
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, a_of(i), d_of(i), m_of(i));
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("rr_grant", bus.req_ready, oh(order[k]));
         push_wr(order[k]);
         step();
      end
      bus.req_valid = '0;
      #1;
      chk("rr_ready_drop", bus.req_ready, 64'd0);
      step();
      chk("rr_wr_stop", bus.pmt_wr_en, 64'd0);
      chk("rr_wr_q_empty", wr_q.size(), 64'd0);

      // Requester 3 reads 0x2A, pool answers 3 cycles after pmt_rd_en
      set_req(3, 1'b0, 8'h2A, '0, '0);
      bus.req_valid = 5'b01000;
      #1;
      chk("rd_grant", bus.req_ready, 5'b01000);
      rd_q.push_back(8'h2A);
      step();
      bus.req_valid = 5'b00011;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("rd_wait_ready", bus.req_ready, 64'd0);
         step();
      end
      bus.pmt_rd_valid = 1'b1;
      bus.pmt_rd_data  = 64'h0000_0000_DEAD_BEEF;
      push_rsp(5'b01000, 64'h0000_0000_DEAD_BEEF, 1'b0);
      #1;
      chk("rd_wait_ready", bus.req_ready, 64'd0);
      step();
      bus.pmt_rd_valid = 1'b0;
      bus.pmt_rd_data  = 64'h0;
      #1;
      chk("rd_after_ready", bus.req_ready, 5'b00001);
      bus.req_valid = '0;
      step();
      chk("rsp_data_hold", bus.rsp_data, 64'h0000_0000_DEAD_BEEF);
      chk("rsp_q_empty", rsp_q.size(), 64'd0);

      // search_busy blocks requester 1 for 5 cycles
      bus.search_busy = 1'b1;
      bus.req_valid   = 5'b00010;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("busy_ready", bus.req_ready, 64'd0);
         step();
      end
      bus.search_busy = 1'b0;
      #1;
      chk("busy_release_grant", bus.req_ready, 5'b00010);
      push_wr(1);
      step();
      bus.search_busy = 1'b1;
      bus.req_valid   = '0;
      #1;
      chk("busy_wr_kept", bus.pmt_wr_en, 64'd1);
      step();
      bus.search_busy = 1'b0;

      // Reset during WAIT_RD abandons the read
      set_req(2, 1'b0, 8'h33, '0, '0);
      bus.req_valid = 5'b00100;
      #1;
      chk("abort_grant", bus.req_ready, 5'b00100);
      rd_q.push_back(8'h33);
      step();
      bus.req_valid = '0;
      step();
      rst = 1'b1;
      #1;
      chk("abort_rst_rsp_data", bus.rsp_data, 64'd0);
      chk("abort_rst_rd_en", bus.pmt_rd_en, 64'd0);
      step();
      rst = 1'b0;
      bus.pmt_rd_valid = 1'b1;
      bus.pmt_rd_data  = 64'h1234;
      step();
      step();
      bus.pmt_rd_valid = 1'b0;
      chk("abort_no_rsp", bus.rsp_valid, 64'd0);
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, a_of(i), d_of(i), m_of(i));
      bus.req_valid = '1;
      #1;
      chk("abort_first_grant", bus.req_ready, 5'b00001);
      push_wr(0);
      step();
      bus.req_valid = '0;
      step();

`ifdef PMT_ARB_TIMEOUT_EN
      // Timeout with no data: err response exactly TIMEOUT_CYC cycles after entering WAIT_RD
      set_req(1, 1'b0, 8'h44, '0, '0);
      bus.req_valid = 5'b00010;
      #1;
      chk("to_grant", bus.req_ready, 5'b00010);
      rd_q.push_back(8'h44);
      step();
      bus.req_valid = '0;
      for (int n = 1; n <= TIMEOUT_CYC; n++) begin
         if (n == TIMEOUT_CYC) push_rsp(5'b00010, 64'd0, 1'b1);
         step();
      end
      chk("to_rsp_seen", rsp_q.size(), 64'd0);

      // Data on the expiry cycle wins
      set_req(2, 1'b0, 8'h55, '0, '0);
      bus.req_valid = 5'b00100;
      #1;
      chk("to_tie_grant", bus.req_ready, 5'b00100);
      rd_q.push_back(8'h55);
      step();
      bus.req_valid = '0;
      for (int n = 1; n < TIMEOUT_CYC; n++) step();
      bus.pmt_rd_valid = 1'b1;
      bus.pmt_rd_data  = 64'hCAFE;
      push_rsp(5'b00100, 64'hCAFE, 1'b0);
      step();
      bus.pmt_rd_valid = 1'b0;
      step();
`endif

      chk("end_wr_q", wr_q.size(), 64'd0);
      chk("end_rd_q", rd_q.size(), 64'd0);
      chk("end_rsp_q", rsp_q.size(), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
